// File: rtl/smi_mem_write_arb_pkg.sv
// Shared types and params_data field layout for the segmented-write arbiter.
// params_data packs {addr[63:0], len_words[31:0], opts[7:0]}, opts in the LSBs.
package smi_mem_write_arb_pkg;

  localparam int PARAMS_W = 104;
  localparam int DATA_W   = 64;

  localparam int OPTS_LSB = 0;
  localparam int OPTS_W   = 8;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 32;
  localparam int ADDR_LSB = 40;
  localparam int ADDR_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } arbState_e;

  function automatic logic [LEN_W-1:0] getLen(input logic [PARAMS_W-1:0] params);
    return params[LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/smi_mem_write_arbiter_grant.sv
// Grant selector: round-robin starting after lastGrant, or lowest-index-first
// when SMI_MEM_WRITE_ARB_FIXED_PRIO_EN is defined.
module smi_rr_grant #(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       lastGrant,
  output logic [IDX_W-1:0]       grant,
  output logic                   anyReq
);

  assign anyReq = |req;

`ifdef SMI_MEM_WRITE_ARB_FIXED_PRIO_EN
  // Fixed priority: scan high to low so the lowest requesting index wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      grant = req[i] ? IDX_W'(i) : grant;
    end
  end
`else
  // Round-robin: scan from farthest to nearest after lastGrant so nearest wins.
  always_comb begin
    int idx;
    grant = '0;
    for (int i = NUM_CLIENTS; i >= 1; i--) begin
      idx   = (int'(lastGrant) + i) % NUM_CLIENTS;
      grant = req[idx] ? IDX_W'(idx) : grant;
    end
  end
`endif

endmodule

// File: rtl/smi_mem_write_arbiter.sv
// Multiplexes client burst writes onto one shared segmented write engine,
// one burst at a time. Build option: SMI_MEM_WRITE_ARB_FIXED_PRIO_EN.
module smi_mem_write_arbiter
  import smi_mem_write_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = 1
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_CLIENTS-1:0]          req_params_valid,
  input  logic [PARAMS_W*NUM_CLIENTS-1:0] req_params_data,
  output logic [NUM_CLIENTS-1:0]          req_params_stop,
  input  logic [NUM_CLIENTS-1:0]          req_write_valid,
  input  logic [DATA_W*NUM_CLIENTS-1:0]   req_write_data,
  output logic [NUM_CLIENTS-1:0]          req_write_stop,
  output logic [NUM_CLIENTS-1:0]          req_done_valid,
  output logic [NUM_CLIENTS-1:0]          req_done_status_ok,
  input  logic [NUM_CLIENTS-1:0]          req_done_stop,
  output logic                            eng_params_valid,
  output logic [PARAMS_W-1:0]             eng_params_data,
  input  logic                            eng_params_stop,
  output logic                            eng_write_valid,
  output logic [DATA_W-1:0]               eng_write_data,
  input  logic                            eng_write_stop,
  input  logic                            eng_done_valid,
  input  logic                            eng_done_status_ok,
  output logic                            eng_done_stop
);

  arbState_e           state;
  arbState_e           nextState;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    lastGrant;
  logic [LEN_W-1:0]    wordCnt;
  logic [IDX_W-1:0]    rrGrant;
  logic                anyReq;
  logic [PARAMS_W-1:0] selParams;
  logic [DATA_W-1:0]   selWord;
  logic                paramsXfer;
  logic                writeXfer;
  logic                doneXfer;

  smi_rr_grant #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) uGrant (
    .req      (req_params_valid),
    .lastGrant(lastGrant),
    .grant    (rrGrant),
    .anyReq   (anyReq)
  );

  assign selParams  = req_params_data[int'(grant)*PARAMS_W +: PARAMS_W];
  assign selWord    = req_write_data[int'(grant)*DATA_W +: DATA_W];
  assign paramsXfer = (state == ST_ISSUE) && !eng_params_stop;
  assign writeXfer  = (state == ST_DATA) && req_write_valid[grant] && !eng_write_stop;
  assign doneXfer   = (state == ST_DONE) && eng_done_valid && !req_done_stop[grant];

  // State, grant and burst word counter registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      lastGrant <= IDX_W'(NUM_CLIENTS - 1);
      wordCnt   <= '0;
    end else begin
      state <= nextState;
      case (state)
        ST_IDLE:  if (anyReq)     grant     <= rrGrant;
        ST_ISSUE: if (paramsXfer) wordCnt   <= getLen(selParams);
        ST_DATA:  if (writeXfer)  wordCnt   <= wordCnt - 32'd1;
        ST_DONE:  if (doneXfer)   lastGrant <= grant;
        default:  ;
      endcase
    end
  end

  // Next state plus zero-latency routing between the granted client and the engine.
  always_comb begin
    nextState          = state;
    eng_params_valid   = 1'b0;
    eng_params_data    = selParams;
    eng_write_valid    = 1'b0;
    eng_write_data     = selWord;
    eng_done_stop      = 1'b1;
    req_params_stop    = '1;
    req_write_stop     = '1;
    req_done_valid     = '0;
    req_done_status_ok = '0;
    case (state)
      ST_IDLE: begin
        nextState = anyReq ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        eng_params_valid       = 1'b1;
        req_params_stop[grant] = eng_params_stop;
        if (paramsXfer) begin
          nextState = (getLen(selParams) == 32'd0) ? ST_DONE : ST_DATA;
        end else begin
          nextState = ST_ISSUE;
        end
      end
      ST_DATA: begin
        eng_write_valid       = req_write_valid[grant];
        req_write_stop[grant] = eng_write_stop;
        if (writeXfer && (wordCnt == 32'd1)) begin
          nextState = ST_DONE;
        end else begin
          nextState = ST_DATA;
        end
      end
      ST_DONE: begin
        eng_done_stop             = req_done_stop[grant];
        req_done_valid[grant]     = eng_done_valid;
        req_done_status_ok[grant] = eng_done_status_ok;
        nextState                 = doneXfer ? ST_IDLE : ST_DONE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

endmodule
